// File: rtl/ldpc_pkg.sv
// Shared definitions for the LDPC rate matcher: FSM state type, redundancy-version
// start-offset fractions and the default codeword length.
package ldpc_pkg;

    localparam int unsigned LDPC_DEFAULT_N = 672;

    typedef enum logic [0:0] {
        StIdle,
        StSend
    } ldpc_state_e;

    // k0 = N * K0_NUM[rv] / K0_DEN
    localparam int unsigned K0_DEN = 4;
    localparam int unsigned K0_NUM [4] = '{0, 1, 2, 3};

    function automatic int unsigned k0_of(input logic [1:0] rv, input int unsigned n);
        return (n * K0_NUM[rv]) / K0_DEN;
    endfunction

endpackage

// File: rtl/ldpc_rm_word_select.sv
// Combinational extraction of OUT_W consecutive circular-buffer bits starting at ptr_i.
// Codeword bit j lives at cw_i[N-1-j]; the first extracted bit lands in the MSB.
module ldpc_rm_word_select
    import ldpc_pkg::*;
#(
    parameter int unsigned CODEWORD_LEN = LDPC_DEFAULT_N,
    parameter int unsigned OUT_W        = 8,
    localparam int unsigned PTR_W       = $clog2(CODEWORD_LEN)
) (
    input  logic [CODEWORD_LEN-1:0] cw_i,
    input  logic [PTR_W-1:0]        ptr_i,
    output logic [OUT_W-1:0]        word_o
);

    localparam logic [PTR_W:0]   N_EXT = (PTR_W + 1)'(CODEWORD_LEN);
    localparam logic [PTR_W-1:0] N_M1  = PTR_W'(CODEWORD_LEN - 1);

    logic [PTR_W:0]   idx;
    logic [PTR_W-1:0] pos;

    // OUT_W < N, so a single conditional subtraction keeps every index in range
    always_comb begin
        word_o = '0;
        idx    = '0;
        pos    = '0;
        for (int i = 0; i < OUT_W; i++) begin
            idx = {1'b0, ptr_i} + (PTR_W + 1)'(i);
            if (idx >= N_EXT) begin
                idx = idx - N_EXT;
            end
            pos = N_M1 - idx[PTR_W-1:0];
            word_o[OUT_W-1-i] = cw_i[pos];
        end
    end

endmodule

// File: rtl/ldpc_rate_matcher.sv
// LDPC rate matcher: captures a codeword and streams e_len bits of its circular buffer,
// starting at the redundancy-version offset k0, as OUT_W-bit words over valid/ready.
// Optional feature: define LDPC_RM_WRAP_COUNT_EN to add the 4-bit wrap_cnt output.
module ldpc_rate_matcher
    import ldpc_pkg::*;
#(
    parameter int unsigned CODEWORD_LEN = LDPC_DEFAULT_N,
    parameter int unsigned OUT_W        = 8,
    parameter int unsigned E_MAX        = 2048,
    localparam int unsigned E_W         = $clog2(E_MAX + 1),
    localparam int unsigned PTR_W       = $clog2(CODEWORD_LEN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [CODEWORD_LEN-1:0] codeword_in,
    input  logic [1:0]              rv_id,
    input  logic [E_W-1:0]          e_len,
    output logic                    in_ready,
    output logic [OUT_W-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
`ifdef LDPC_RM_WRAP_COUNT_EN
    output logic [3:0]              wrap_cnt,
`endif
    output logic                    done
);

    localparam logic [E_W-1:0]   OUT_W_E = E_W'(OUT_W);
    localparam logic [PTR_W:0]   OUT_W_P = (PTR_W + 1)'(OUT_W);
    localparam logic [PTR_W:0]   N_P     = (PTR_W + 1)'(CODEWORD_LEN);

    ldpc_state_e             state_q, state_d;
    logic [CODEWORD_LEN-1:0] cw_q, cw_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic [E_W-1:0]          rem_q, rem_d;
    logic [OUT_W-1:0]        out_data_q, out_data_d;
    logic                    valid_q, valid_d;
    logic                    last_q, last_d;
    logic                    done_q, done_d;
`ifdef LDPC_RM_WRAP_COUNT_EN
    logic [3:0]              wrap_q, wrap_d;
`endif

    logic                    hs;
    logic [E_W-1:0]          step;
    logic [PTR_W:0]          ptr_sum;
    logic                    wrapped;
    logic [PTR_W-1:0]        ptr_adv;
    logic [OUT_W-1:0]        word_next;
    logic [OUT_W-1:0]        keep_mask;

    // Word at the next pointer; outputs are registered, so select from next-state values
    ldpc_rm_word_select #(
        .CODEWORD_LEN(CODEWORD_LEN),
        .OUT_W       (OUT_W)
    ) u_word_select (
        .cw_i  (cw_d),
        .ptr_i (ptr_d),
        .word_o(word_next)
    );

    // Next-state logic for the control FSM, datapath and registered outputs
    always_comb begin
        state_d = state_q;
        cw_d    = cw_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
`ifdef LDPC_RM_WRAP_COUNT_EN
        wrap_d  = wrap_q;
`endif

        hs      = valid_q & out_ready;
        step    = (rem_q > OUT_W_E) ? OUT_W_E : rem_q;
        ptr_sum = {1'b0, ptr_q} + OUT_W_P;
        wrapped = (ptr_sum >= N_P);
        ptr_adv = wrapped ? PTR_W'(ptr_sum - N_P) : PTR_W'(ptr_sum);

        unique case (state_q)
            StIdle: begin
                if (start) begin
`ifdef LDPC_RM_WRAP_COUNT_EN
                    wrap_d = 4'd0;
`endif
                    if (e_len != '0) begin
                        cw_d    = codeword_in;
                        ptr_d   = PTR_W'(k0_of(rv_id, CODEWORD_LEN));
                        rem_d   = e_len;
                        state_d = StSend;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StSend: begin
                if (hs) begin
                    ptr_d = ptr_adv;
                    rem_d = rem_q - step;
`ifdef LDPC_RM_WRAP_COUNT_EN
                    if (wrapped && (wrap_q != 4'hF)) begin
                        wrap_d = wrap_q + 4'd1;
                    end
`endif
                    if (last_q) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Keep only the first rem_d bits (MSB-first) of a short final word
        keep_mask = '0;
        for (int i = 0; i < OUT_W; i++) begin
            keep_mask[OUT_W-1-i] = (int'(rem_d) > i);
        end

        valid_d    = (state_d == StSend);
        last_d     = valid_d && (rem_d <= OUT_W_E);
        out_data_d = valid_d ? (word_next & keep_mask) : '0;
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cw_q       <= '0;
            ptr_q      <= '0;
            rem_q      <= '0;
            out_data_q <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef LDPC_RM_WRAP_COUNT_EN
            wrap_q     <= 4'd0;
`endif
        end else begin
            state_q    <= state_d;
            cw_q       <= cw_d;
            ptr_q      <= ptr_d;
            rem_q      <= rem_d;
            out_data_q <= out_data_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            done_q     <= done_d;
`ifdef LDPC_RM_WRAP_COUNT_EN
            wrap_q     <= wrap_d;
`endif
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_data  = out_data_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign done      = done_q;
`ifdef LDPC_RM_WRAP_COUNT_EN
    assign wrap_cnt  = wrap_q;
`endif

endmodule

// File: tb/tb_ldpc_rate_matcher.sv
// Self-checking bench for ldpc_rate_matcher: directed blocks plus randomized blocks with
// random backpressure and stray start pulses, checked against a stream-position model.
module tb_ldpc_rate_matcher;

    localparam int N    = 672;
    localparam int W    = 8;
    localparam int EMAX = 2048;
    localparam int EW   = $clog2(EMAX + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [N-1:0]  codeword_in;
    logic [1:0]    rv_id;
    logic [EW-1:0] e_len;
    logic          in_ready;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          done;
`ifdef LDPC_RM_WRAP_COUNT_EN
    logic [3:0]    wrap_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ldpc_rate_matcher #(
        .CODEWORD_LEN(N),
        .OUT_W       (W),
        .E_MAX       (EMAX)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .codeword_in(codeword_in),
        .rv_id      (rv_id),
        .e_len      (e_len),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
`ifdef LDPC_RM_WRAP_COUNT_EN
        .wrap_cnt   (wrap_cnt),
`endif
        .done       (done)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Word k of the stream: stream bit s maps to codeword bit (k0 + s) mod N, zero past e
    function automatic logic [W-1:0] model_word(input logic [N-1:0] cw, input int k0,
                                                input int e, input int k);
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < W; i++) begin
            int s;
            s = k * W + i;
            if (s < e) w[W-1-i] = cw[N-1-((k0 + s) % N)];
        end
        return w;
    endfunction

    function automatic logic [N-1:0] rand_cw();
        logic [N-1:0] c;
        for (int i = 0; i < N / 32; i++) c[i*32 +: 32] = $urandom;
        return c;
    endfunction

    task automatic run_block(input logic [N-1:0] cw, input logic [1:0] rv, input int e,
                             input bit rnd_ready, input bit stray,
                             output int nwords, output logic [W-1:0] first_w,
                             output logic [W-1:0] last_w);
        int           k0;
        int           n;
        int           idx;
        int           cyc;
        bit           rdy;
        bit           stalled;
        logic [W-1:0] held;
        k0      = (N * int'(rv)) / 4;
        n       = (e + W - 1) / W;
        idx     = 0;
        cyc     = 0;
        stalled = 1'b0;
        held    = '0;
        first_w = '0;
        last_w  = '0;
        check_eq("in_ready_idle", in_ready, 1);
        codeword_in = cw;
        rv_id       = rv;
        e_len       = EW'(e);
        out_ready   = 1'b0;
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("in_ready_send", in_ready, 0);
        while (idx < n) begin
            if (cyc > n * 16 + 64) begin
                check_eq("timeout_words", idx, n);
                break;
            end
            check_eq("valid", out_valid, 1);
            check_eq("data", out_data, model_word(cw, k0, e, idx));
            check_eq("last", out_last, idx == n - 1);
            check_eq("no_early_done", done, 0);
            if (stalled) check_eq("hold", out_data, held);
            if (idx == 0) first_w = out_data;
            last_w = out_data;
            if (stray) begin
                start       = 1'($urandom_range(0, 1));
                codeword_in = rand_cw();
                rv_id       = 2'($urandom);
                e_len       = EW'($urandom);
            end
            rdy       = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = rdy;
            held      = out_data;
            stalled   = !rdy;
            @(posedge clk); #1;
            cyc++;
            if (rdy) idx++;
        end
        start     = 1'b0;
        out_ready = 1'b0;
        nwords    = idx;
        check_eq("done_pulse", done, 1);
        check_eq("valid_after_last", out_valid, 0);
        check_eq("in_ready_after", in_ready, 1);
`ifdef LDPC_RM_WRAP_COUNT_EN
        begin
            int wexp;
            wexp = (k0 + n * W) / N;
            if (wexp > 15) wexp = 15;
            check_eq("wrap_cnt", wrap_cnt, wexp);
        end
`endif
        @(posedge clk); #1;
        check_eq("done_one_cycle", done, 0);
    endtask

    initial begin
        logic [N-1:0] cw;
        logic [W-1:0] fw;
        logic [W-1:0] lw;
        int           nw;

        reset       = 1'b1;
        start       = 1'b0;
        out_ready   = 1'b0;
        codeword_in = '0;
        rv_id       = 2'd0;
        e_len       = '0;
        @(posedge clk); #1;
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_data", out_data, 0);
        check_eq("rst_last", out_last, 0);
        check_eq("rst_done", done, 0);
`ifdef LDPC_RM_WRAP_COUNT_EN
        check_eq("rst_wrap", wrap_cnt, 0);
`endif
        reset = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_in_ready", in_ready, 1);

        // Full block, rv0, alternating pattern
        cw = {336{2'b10}};
        run_block(cw, 2'd0, 672, 1'b0, 1'b0, nw, fw, lw);
        check_eq("alt_count", nw, 84);
        check_eq("alt_first", fw, 8'hAA);
        check_eq("alt_last", lw, 8'hAA);

        // Single set bit at k0 for rv2
        cw = '0;
        cw[N-1-336] = 1'b1;
        run_block(cw, 2'd2, 16, 1'b0, 1'b0, nw, fw, lw);
        check_eq("rv2_count", nw, 2);
        check_eq("rv2_word1", fw, 8'h80);
        check_eq("rv2_word2", lw, 8'h00);

        // Two full passes of the circular buffer from rv3
        run_block(rand_cw(), 2'd3, 1344, 1'b0, 1'b0, nw, fw, lw);
        check_eq("rv3_count", nw, 168);

        // Partial last word
        cw = {336{2'b10}};
        run_block(cw, 2'd0, 12, 1'b0, 1'b0, nw, fw, lw);
        check_eq("short_first", fw, 8'hAA);
        check_eq("short_last", lw, 8'hA0);

        // Zero-length request: done only
        e_len = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("zero_done", done, 1);
        check_eq("zero_valid", out_valid, 0);
        check_eq("zero_in_ready", in_ready, 1);
        @(posedge clk); #1;
        check_eq("zero_done_clear", done, 0);

        // Randomized blocks with backpressure and stray starts
        for (int b = 0; b < 6; b++) begin
            run_block(rand_cw(), 2'($urandom), int'($urandom_range(1, EMAX)), 1'b1, 1'b1,
                      nw, fw, lw);
        end

        // Reset in the middle of a block
        codeword_in = rand_cw();
        rv_id       = 2'd1;
        e_len       = EW'(672);
        out_ready   = 1'b1;
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        check_eq("pre_rst_valid", out_valid, 1);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_valid", out_valid, 0);
        check_eq("mid_rst_data", out_data, 0);
        check_eq("mid_rst_last", out_last, 0);
        check_eq("mid_rst_done", done, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b0;
        check_eq("post_rst_in_ready", in_ready, 1);
        repeat (2) begin
            @(posedge clk); #1;
            check_eq("post_rst_no_done", done, 0);
            check_eq("post_rst_no_valid", out_valid, 0);
        end
        run_block(rand_cw(), 2'd1, 40, 1'b1, 1'b0, nw, fw, lw);
        check_eq("restart_count", nw, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
